// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 round constants, IV, schedule sigma functions and sequencer states
package sha256_pkg;

    typedef enum logic [2:0] {IDLE, KICK, PRIME, ROUND, CAPTURE} state_t;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] k_const(input logic [5:0] t);
        return K_ROM[t];
    endfunction

    function automatic logic [31:0] iv_word(input int i);
        return IV[255-32*i -: 32];
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: 16-word message schedule window, loaded from the stream then self-expanding
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        expand,
    input  logic [31:0] data,
    output logic [31:0] w0
);

    logic [31:0] w [16];
    logic [31:0] nxt;

    assign nxt = load ? data : sig1(w[14]) + w[9] + sig0(w[1]) + w[0];
    assign w0  = w[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) w[i] <= '0;
        end else if (load || expand) begin
            for (int i = 0; i < 15; i++) w[i] <= w[i+1];
            w[15] <= nxt;
        end
    end

endmodule

// File: rtl/sha256_round_sched.sv
// sha256_round_sched: sequences one 512-bit block through xunitF and chains the digest
module sha256_round_sched
    import sha256_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int UNIT_DELAY = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init,
    input  logic              msg_valid,
    input  logic [DATA_W-1:0] msg_data,
    output logic              msg_ready,
    output logic              busy,
    output logic              done,
    output logic [255:0]      digest,
    output logic              unit_run,
    output logic [7:0]        unit_delay,
    output logic [255:0]      unit_state,
    output logic [DATA_W-1:0] unit_w,
    output logic [DATA_W-1:0] unit_k,
    input  logic [255:0]      unit_out
);

    state_t      state;
    logic [4:0]  word_cnt;
    logic [5:0]  round_cnt;
    logic [7:0]  prime_cnt;
    logic [31:0] h [8];
    logic [31:0] w0;
    logic        accept;

    assign msg_ready  = (state == IDLE) && (word_cnt < 5'd16);
    assign accept     = msg_valid && msg_ready;
    assign busy       = state != IDLE;
    assign unit_delay = 8'(UNIT_DELAY);
    assign digest     = {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
    // H only changes in IDLE or CAPTURE, so the unit sees a stable state through KICK and PRIME
    assign unit_state = digest;
    assign unit_w     = (state == ROUND) ? w0 : '0;
    assign unit_k     = (state == ROUND) ? k_const(round_cnt) : '0;

    sha256_msg_sched u_sched (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .expand (state == ROUND),
        .data   (msg_data),
        .w0     (w0)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            word_cnt  <= '0;
            round_cnt <= '0;
            prime_cnt <= '0;
            unit_run  <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < 8; i++) h[i] <= iv_word(i);
        end else begin
            unit_run <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (init && word_cnt == 5'd0)
                        for (int i = 0; i < 8; i++) h[i] <= iv_word(i);
                    if (accept) begin
                        word_cnt <= word_cnt + 5'd1;
                        if (word_cnt == 5'd15) begin
                            state    <= KICK;
                            unit_run <= 1'b1;
                        end
                    end
                end
                KICK: begin
                    state     <= PRIME;
                    prime_cnt <= '0;
                end
                PRIME: begin
                    if (prime_cnt == 8'(UNIT_DELAY)) begin
                        state     <= ROUND;
                        round_cnt <= '0;
                    end else begin
                        prime_cnt <= prime_cnt + 8'd1;
                    end
                end
                ROUND: begin
                    round_cnt <= round_cnt + 6'd1;
                    if (round_cnt == 6'd63) state <= CAPTURE;
                end
                CAPTURE: begin
                    for (int i = 0; i < 8; i++) h[i] <= h[i] + unit_out[255-32*i -: 32];
                    word_cnt <= '0;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_round_sched.sv
// tb_sha256_round_sched: drives known SHA-256 blocks through the sequencer with an attached round-unit model
module tb_sha256_round_sched;

    localparam logic [255:0] IV_D  = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] ABC_D = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] TWO_D = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    logic         clk = 1'b0;
    logic         rst_n, init, msg_valid, msg_ready, busy, done, unit_run;
    logic [31:0]  msg_data, unit_w, unit_k;
    logic [7:0]   unit_delay;
    logic [255:0] digest, unit_state, unit_out;

    typedef struct {
        bit           chk;
        logic [255:0] d;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0, checks = 0, cyc = 0, done_cnt = 0, exp_done = 0;
    logic [31:0] abc [16];
    logic [31:0] b1 [16];
    logic [31:0] b2 [16];

    sha256_round_sched #(.DATA_W(32), .UNIT_DELAY(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init       (init),
        .msg_valid  (msg_valid),
        .msg_data   (msg_data),
        .msg_ready  (msg_ready),
        .busy       (busy),
        .done       (done),
        .digest     (digest),
        .unit_run   (unit_run),
        .unit_delay (unit_delay),
        .unit_state (unit_state),
        .unit_w     (unit_w),
        .unit_k     (unit_k),
        .unit_out   (unit_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string n, input logic [255:0] a, input logic [255:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endfunction

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        logic [63:0] y;
        y = {x, x} >> n;
        return y[31:0];
    endfunction

    function automatic logic [255:0] rnd(input logic [255:0] s, input logic [31:0] w, input logic [31:0] k);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    // Round-unit model: loads unit_state one cycle after the run pulse, then rounds every cycle
    logic         ld  = 1'b0;
    logic [255:0] ust = '0;
    always @(posedge clk) begin
        ld  <= unit_run;
        ust <= ld ? unit_state : rnd(ust, unit_w, unit_k);
    end
    assign unit_out = ust;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("spurious_done", 1'b1, 1'b0);
            end else begin
                e = sb.pop_front();
                if (e.chk) chk("digest", digest, e.d);
            end
        end
    end

    task automatic push(input bit c, input logic [255:0] d);
        exp_t e;
        e.chk = c;
        e.d   = d;
        sb.push_back(e);
        exp_done++;
    endtask

    task automatic send_block(input logic [31:0] w [16], input int first, input int cnt,
                              input int gmax, input bit init_first, input bit hold);
        int g, n;
        for (int i = first; i < first + cnt; i++) begin
            g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
            repeat (g) begin
                @(negedge clk);
                msg_valid = 1'b0;
            end
            @(negedge clk);
            msg_valid = 1'b1;
            msg_data  = w[i];
            init      = init_first && (i == first);
            n = 0;
            while (!msg_ready && n < 300) begin
                @(negedge clk);
                n++;
            end
            chk("ready_timeout", n < 300, 1'b1);
            @(posedge clk);
        end
        #1;
        msg_valid = hold;
        init      = 1'b0;
        if (hold) begin
            repeat (60) begin
                @(negedge clk);
                chk("ready_while_busy", msg_ready, 1'b0);
                msg_data = $urandom;
            end
            msg_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", n < 200, 1'b1);
    endtask

    initial begin
        int t0, rel;
        foreach (abc[i]) begin abc[i] = '0; b2[i] = '0; end
        abc[0] = 32'h61626380;
        abc[15] = 32'h00000018;
        b1 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
               32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
               32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
               32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        b2[15] = 32'h000001c0;

        rst_n = 1'b0; init = 1'b0; msg_valid = 1'b0; msg_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_digest", digest, IV_D);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_run", unit_run, 1'b0);
        chk("reset_w", unit_w, 32'h0);
        chk("reset_delay", unit_delay, 8'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", msg_ready, 1'b1);

        // init alone, then "abc" with cycle-level timing checks
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        send_block(abc, 0, 16, 0, 1'b0, 1'b0);
        push(1'b1, ABC_D);
        t0 = cyc - 1;
        repeat (69) begin
            @(negedge clk);
            rel = cyc - t0;
            chk("unit_run_timing", unit_run, rel == 1);
            chk("busy_timing", busy, rel >= 1 && rel <= 67);
            chk("done_timing", done, rel == 68);
            if (rel == 3) begin
                chk("k_first", unit_k, 32'h428a2f98);
                chk("w_first", unit_w, 32'h61626380);
            end
            if (rel == 66) chk("k_last", unit_k, 32'hc67178f2);
            if (rel == 67) chk("k_capture", unit_k, 32'h0);
            if (rel == 68) chk("ready_after", msg_ready, 1'b1);
        end

        // random gaps, valid held through busy
        send_block(abc, 0, 16, 5, 1'b1, 1'b1);
        push(1'b1, ABC_D);
        wait_done();

        // two-block message chained without init
        send_block(b1, 0, 16, 0, 1'b1, 1'b0);
        push(1'b0, '0);
        wait_done();
        send_block(b2, 0, 16, 2, 1'b0, 1'b0);
        push(1'b1, TWO_D);
        wait_done();

        // reset at round 30 discards the block
        send_block(abc, 0, 16, 0, 1'b1, 1'b0);
        repeat (33) @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("abort_digest", digest, IV_D);
        chk("abort_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        send_block(abc, 0, 16, 1, 1'b0, 1'b0);
        push(1'b1, ABC_D);
        wait_done();

        // init with a partial block is ignored; init with the first word reloads
        send_block(abc, 0, 5, 0, 1'b0, 1'b0);
        @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        chk("init_ignored", digest, ABC_D);
        send_block(abc, 5, 11, 0, 1'b0, 1'b0);
        push(1'b0, '0);
        wait_done();
        send_block(abc, 0, 16, 0, 1'b1, 1'b0);
        push(1'b1, ABC_D);
        wait_done();

        repeat (3) @(negedge clk);
        chk("done_count", done_cnt, exp_done);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
